// File: rtl/jtag_uart_avalon_poller_pkg.sv
// Shared JTAG-UART register map, field positions and poller FSM states.
package jtag_uart_avalon_poller_pkg;

   localparam logic JTAG_ADDR_DATA = 1'b0;
   localparam logic JTAG_ADDR_CTRL = 1'b1;

   localparam int unsigned RVALID_BIT = 15;
   localparam int unsigned RAVAIL_MSB = 31;
   localparam int unsigned RAVAIL_LSB = 16;
   localparam int unsigned WSPACE_MSB = 31;
   localparam int unsigned WSPACE_LSB = 16;

   typedef enum logic [1:0] {
      S_GAP     = 2'd0,
      S_RD_DATA = 2'd1,
      S_RD_CTRL = 2'd2,
      S_WR_DATA = 2'd3
   } state_e;

endpackage

// File: rtl/jtag_uart_avalon_poller.sv
// Avalon-MM poller for the JTAG-UART: RX byte strobe stream plus single-byte TX path.
// Optional waitrequest stall timeout (adds oTIMEOUT) is enabled by JTAG_POLL_TIMEOUT_EN.
module jtag_uart_avalon_poller
   import jtag_uart_avalon_poller_pkg::*;
#(
   parameter int unsigned POLL_GAP    = 16,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic        iCLK,
   input  logic        iRST,
   output logic        oJTAG_SLAVE_ADDR,
   output logic        oJTAG_SLAVE_RDREQ,
   input  logic [31:0] iJTAG_SLAVE_RDDATA,
   output logic        oJTAG_SLAVE_WRREQ,
   output logic [31:0] oJTAG_SLAVE_WRDATA,
   input  logic        iJTAG_SLAVE_WAIT,
   output logic [7:0]  oDATA_TO_PARSE,
   output logic        oDATA_TO_PARSE_VALID,
`ifdef JTAG_POLL_TIMEOUT_EN
   output logic        oTIMEOUT,
`endif
   input  logic [7:0]  iTX_BYTE,
   input  logic        iTX_REQ,
   output logic        oTX_BUSY
);

   localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST = (POLL_GAP > 0) ? GW'(POLL_GAP - 1) : '0;

   state_e      state_q;
   logic [GW-1:0] gap_q;
   logic        addr_q;
   logic        rdreq_q;
   logic        wrreq_q;
   logic [7:0]  tx_byte_q;
   logic        busy_q;
   logic [7:0]  data_q;
   logic        valid_q;

   logic        req_w;
   logic        rvalid_w;
   logic [15:0] ravail_w;
   logic [15:0] wspace_w;
   logic        unused_w;

   assign req_w    = rdreq_q | wrreq_q;
   assign rvalid_w = iJTAG_SLAVE_RDDATA[RVALID_BIT];
   assign ravail_w = iJTAG_SLAVE_RDDATA[RAVAIL_MSB:RAVAIL_LSB];
   assign wspace_w = iJTAG_SLAVE_RDDATA[WSPACE_MSB:WSPACE_LSB];
   assign unused_w = ^{iJTAG_SLAVE_RDDATA[14:8], TIMEOUT_CYC != 0};

`ifdef JTAG_POLL_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   logic [TW-1:0] stall_q;
   logic          timeout_q;
   assign oTIMEOUT = timeout_q;
`endif

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q   <= S_GAP;
         gap_q     <= '0;
         addr_q    <= 1'b0;
         rdreq_q   <= 1'b0;
         wrreq_q   <= 1'b0;
         tx_byte_q <= '0;
         busy_q    <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
`ifdef JTAG_POLL_TIMEOUT_EN
         stall_q   <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         valid_q <= 1'b0;
`ifdef JTAG_POLL_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         if (!busy_q && iTX_REQ) begin
            tx_byte_q <= iTX_BYTE;
            busy_q    <= 1'b1;
         end
         // A request state entered from a completion spends one cycle with the request low,
         // so every completion is followed by a deasserted cycle.
         case (state_q)
            S_GAP: begin
               if (gap_q == GAP_LAST) begin
                  gap_q   <= '0;
                  rdreq_q <= 1'b1;
                  if (busy_q) begin
                     state_q <= S_RD_CTRL;
                     addr_q  <= JTAG_ADDR_CTRL;
                  end else begin
                     state_q <= S_RD_DATA;
                     addr_q  <= JTAG_ADDR_DATA;
                  end
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
            end
            S_RD_DATA: begin
               if (!rdreq_q) begin
                  addr_q  <= JTAG_ADDR_DATA;
                  rdreq_q <= 1'b1;
               end else if (!iJTAG_SLAVE_WAIT) begin
                  rdreq_q <= 1'b0;
                  if (rvalid_w) begin
                     data_q  <= iJTAG_SLAVE_RDDATA[7:0];
                     valid_q <= 1'b1;
                  end
                  if (rvalid_w && (ravail_w > 16'd1) && !busy_q) state_q <= S_RD_DATA;
                  else                                           state_q <= S_GAP;
               end
            end
            S_RD_CTRL: begin
               if (!rdreq_q) begin
                  addr_q  <= JTAG_ADDR_CTRL;
                  rdreq_q <= 1'b1;
               end else if (!iJTAG_SLAVE_WAIT) begin
                  rdreq_q <= 1'b0;
                  state_q <= (wspace_w != 16'd0) ? S_WR_DATA : S_RD_DATA;
               end
            end
            S_WR_DATA: begin
               if (!wrreq_q) begin
                  addr_q  <= JTAG_ADDR_DATA;
                  wrreq_q <= 1'b1;
               end else if (!iJTAG_SLAVE_WAIT) begin
                  wrreq_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= S_RD_DATA;
               end
            end
            default: state_q <= S_GAP;
         endcase
`ifdef JTAG_POLL_TIMEOUT_EN
         // Placed after the FSM so an expiring stall overrides the held request.
         if (req_w && !iJTAG_SLAVE_WAIT) begin
            stall_q <= '0;
         end else if (req_w) begin
            if (stall_q == TMO_LAST) begin
               stall_q   <= '0;
               rdreq_q   <= 1'b0;
               wrreq_q   <= 1'b0;
               state_q   <= S_GAP;
               timeout_q <= 1'b1;
            end else begin
               stall_q <= stall_q + 1'b1;
            end
         end
`endif
      end
   end

   assign oJTAG_SLAVE_ADDR     = addr_q;
   assign oJTAG_SLAVE_RDREQ    = rdreq_q;
   assign oJTAG_SLAVE_WRREQ    = wrreq_q;
   assign oJTAG_SLAVE_WRDATA   = {24'd0, tx_byte_q};
   assign oDATA_TO_PARSE       = data_q;
   assign oDATA_TO_PARSE_VALID = valid_q;
   assign oTX_BUSY             = busy_q;

endmodule

// File: tb/tb_jtag_uart_avalon_poller.sv
// Self-checking bench for jtag_uart_avalon_poller: a JTAG-UART slave model with a byte FIFO,
// WSPACE schedule and waitrequest injection; define JTAG_POLL_TIMEOUT_EN to cover the stall timeout.
module tb_jtag_uart_avalon_poller;

   localparam int POLL_GAP = 16;
   localparam int TMO      = 8;
   localparam int K_DATA = 0, K_CTRL = 1, K_WR = 2, K_GAPDEC = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        addr_o, rdreq_o, wrreq_o, valid_o, busy_o;
   logic [31:0] wrdata_o;
   logic [7:0]  data_o;
   logic [31:0] rddata = '0;
   logic        wait_i = 1'b0;
   logic [7:0]  tx_byte = '0;
   logic        tx_req = 1'b0;
`ifdef JTAG_POLL_TIMEOUT_EN
   logic        timeout_o;
`endif

   jtag_uart_avalon_poller #(.POLL_GAP(POLL_GAP), .TIMEOUT_CYC(TMO)) dut (
      .iCLK(clk), .iRST(rst),
      .oJTAG_SLAVE_ADDR(addr_o), .oJTAG_SLAVE_RDREQ(rdreq_o), .iJTAG_SLAVE_RDDATA(rddata),
      .oJTAG_SLAVE_WRREQ(wrreq_o), .oJTAG_SLAVE_WRDATA(wrdata_o), .iJTAG_SLAVE_WAIT(wait_i),
      .oDATA_TO_PARSE(data_o), .oDATA_TO_PARSE_VALID(valid_o),
`ifdef JTAG_POLL_TIMEOUT_EN
      .oTIMEOUT(timeout_o),
`endif
      .iTX_BYTE(tx_byte), .iTX_REQ(tx_req), .oTX_BUSY(busy_o)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   byte unsigned fifo[$], rx_log[$], wr_log[$], acc_log[$];
   int unsigned wspace_q[$], stall_plan[$];
   int kind_log[$];
   bit rand_mode = 0, exp_valid = 0, model_busy = 0;
   bit prev_active = 0, prev_wait = 0, prev_busy = 0, tx_req_now = 0;
   byte unsigned exp_byte = 0, model_tx = 0, tx_byte_now = 0;
   int exp_kind = K_GAPDEC, exp_idle = POLL_GAP, idle_cnt = 0;
   int stall_left = 0, stall_cnt = 0, last_hold = 0, to_count = 0, drops = 0, wr_stall = 0;
   logic st_addr, st_rd, st_wr;
   logic [31:0] st_wd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One cycle: check outputs, act as the slave for this cycle, advance to the next sample point.
   task automatic step();
      bit rq, exp_to, done;
      int kind, ravail, ws;
      logic [31:0] rd;
      rq   = (rdreq_o === 1'b1) || (wrreq_o === 1'b1);
      kind = (wrreq_o === 1'b1) ? K_WR : ((addr_o === 1'b1) ? K_CTRL : K_DATA);
      check("rx_valid", valid_o, exp_valid);
      if (exp_valid) check("rx_byte", data_o, exp_byte);
      if (valid_o === 1'b1) rx_log.push_back(data_o);
      exp_valid = 0;
      check("tx_busy", busy_o, model_busy);
`ifdef JTAG_POLL_TIMEOUT_EN
      exp_to = prev_active && prev_wait && (stall_cnt == TMO);
      check("timeout_pulse", timeout_o, exp_to);
      if (timeout_o === 1'b1) to_count++;
`else
      exp_to = 0;
`endif
      if (prev_active && prev_wait) check("req_held", rq, !exp_to);
      if (prev_active && !prev_wait) check("req_release", rq, 0);
      if (exp_to) begin
         drops++;
         idle_cnt = 0;
         exp_kind = K_GAPDEC;
         exp_idle = POLL_GAP;
      end
      if (rq && !(prev_active && prev_wait)) begin
         check("req_kind", kind, (exp_kind == K_GAPDEC) ? (prev_busy ? K_CTRL : K_DATA) : exp_kind);
         check("idle_cycles", idle_cnt, exp_idle);
         check("rd_wr_excl", rdreq_o & wrreq_o, 0);
         if (kind == K_WR) begin
            check("wr_addr", addr_o, 0);
            check("wr_data", wrdata_o, {24'd0, model_tx});
         end
         kind_log.push_back(kind);
         st_addr = addr_o; st_rd = rdreq_o; st_wr = wrreq_o; st_wd = wrdata_o;
         stall_cnt = 0;
         if (kind == K_WR && wr_stall > 0) stall_left = wr_stall;
         else if (stall_plan.size() > 0) stall_left = stall_plan.pop_front();
         else if (rand_mode && $urandom_range(0, 3) == 0) stall_left = $urandom_range(1, 4);
         else stall_left = 0;
      end else if (rq) begin
         check("hold_addr", addr_o, st_addr);
         check("hold_rdreq", rdreq_o, st_rd);
         check("hold_wrreq", wrreq_o, st_wr);
         if (st_wr) check("hold_wrdata", wrdata_o, st_wd);
      end else begin
         idle_cnt++;
      end

      wait_i = rq && (stall_left > 0);
      if (wait_i) begin stall_left--; stall_cnt++; end
      done = rq && !wait_i;
      rd = $urandom;
      rd[15] = 1'b1;
      if (done) begin
         last_hold = stall_cnt + 1;
         stall_cnt = 0;
         idle_cnt  = 0;
         case (kind)
            K_DATA: begin
               if (fifo.size() > 0) begin
                  ravail = fifo.size();
                  rd = {16'(ravail), 1'b1, 7'($urandom), fifo[0]};
                  exp_byte  = fifo.pop_front();
                  exp_valid = 1;
                  if (ravail > 1 && !model_busy) begin exp_kind = K_DATA; exp_idle = 1; end
                  else begin exp_kind = K_GAPDEC; exp_idle = POLL_GAP; end
               end else begin
                  rd = {16'd0, 1'b0, 15'($urandom)};
                  exp_kind = K_GAPDEC; exp_idle = POLL_GAP;
               end
            end
            K_CTRL: begin
               if (wspace_q.size() > 0) ws = wspace_q.pop_front();
               else if (rand_mode) ws = ($urandom_range(0, 2) == 0) ? 0 : 32;
               else ws = 64;
               rd = {16'(ws), 16'($urandom)};
               exp_kind = (ws != 0) ? K_WR : K_DATA;
               exp_idle = 1;
            end
            default: begin
               wr_log.push_back(wrdata_o[7:0]);
               exp_kind = K_DATA;
               exp_idle = 1;
            end
         endcase
      end
      rddata    = rd;
      prev_busy = model_busy;
      tx_req    = tx_req_now;
      tx_byte   = tx_byte_now;
      if (tx_req_now && !model_busy) begin
         model_busy = 1;
         model_tx   = tx_byte_now;
         acc_log.push_back(tx_byte_now);
      end
      if (done && kind == K_WR) model_busy = 0;
      tx_req_now  = 0;
      prev_active = rq;
      prev_wait   = wait_i;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_rdreq", rdreq_o, 0);
      check("rst_wrreq", wrreq_o, 0);
      check("rst_addr", addr_o, 0);
      check("rst_valid", valid_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_data", data_o, 0);
      check("rst_wrdata", wrdata_o, 0);
`ifdef JTAG_POLL_TIMEOUT_EN
      check("rst_timeout", timeout_o, 0);
`endif
      wait_i = 1'b0; tx_req = 1'b0; rddata = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_rdreq", rdreq_o, 0);
      rst = 1'b0;
      exp_valid = 0; model_busy = 0; prev_active = 0; prev_wait = 0; prev_busy = 0;
      exp_kind = K_GAPDEC; exp_idle = POLL_GAP; idle_cnt = 0; stall_left = 0; stall_cnt = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, ctrl_cnt;
      byte unsigned pushed[$];
      do_reset();

      // Two-byte burst: back-to-back reads, then a full gap.
      fifo.push_back(8'hFE); fifo.push_back(8'h01);
      rx_log.delete(); kind_log.delete();
      repeat (60) step();
      check("t1_rx_count", rx_log.size(), 2);
      if (rx_log.size() >= 2) begin
         check("t1_rx0", rx_log[0], 8'hFE);
         check("t1_rx1", rx_log[1], 8'h01);
      end

      // Five waitrequest cycles on a data read.
      stall_plan.push_back(5); fifo.push_back(8'h3C); rx_log.delete();
      n = 0;
      while (rx_log.size() == 0 && n < 60) begin step(); n++; end
      check("t2_hold_cycles", last_hold, 6);
      repeat (5) step();
      check("t2_rx_count", rx_log.size(), 1);
      if (rx_log.size() >= 1) check("t2_rx_byte", rx_log[0], 8'h3C);

      // TX with room available.
      kind_log.delete(); wr_log.delete();
      tx_req_now = 1; tx_byte_now = 8'h5A;
      step();
      n = 0;
      while (kind_log.size() < 3 && n < 80) begin step(); n++; end
      check("t3_seq_len", kind_log.size(), 3);
      if (kind_log.size() >= 3) begin
         check("t3_seq0", kind_log[0], K_CTRL);
         check("t3_seq1", kind_log[1], K_WR);
         check("t3_seq2", kind_log[2], K_DATA);
      end
      check("t3_wr_count", wr_log.size(), 1);
      if (wr_log.size() >= 1) check("t3_wr_byte", wr_log[0], 8'h5A);

      // TX blocked by WSPACE=0 three times; a second request meanwhile is dropped.
      wspace_q.push_back(0); wspace_q.push_back(0); wspace_q.push_back(0); wspace_q.push_back(8);
      kind_log.delete(); wr_log.delete();
      tx_req_now = 1; tx_byte_now = 8'h77;
      step();
      n = 0;
      while (wr_log.size() == 0 && n < 300) begin
         if (n == 30) begin tx_req_now = 1; tx_byte_now = 8'h11; end
         step(); n++;
      end
      ctrl_cnt = 0;
      foreach (kind_log[i]) if (kind_log[i] == K_CTRL) ctrl_cnt++;
      check("t4_ctrl_reads", ctrl_cnt, 4);
      check("t4_wr_count", wr_log.size(), 1);
      if (wr_log.size() >= 1) check("t4_wr_byte", wr_log[0], 8'h77);
      repeat (20) step();
      check("t4_wr_count_after", wr_log.size(), 1);

      // Randomized traffic against the slave model.
      acc_log.delete(); wr_log.delete(); rx_log.delete(); pushed.delete();
      rand_mode = 1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 19) == 0 && fifo.size() < 6) begin
            fifo.push_back(8'($urandom));
            pushed.push_back(fifo[fifo.size() - 1]);
         end
         if ($urandom_range(0, 29) == 0) begin tx_req_now = 1; tx_byte_now = 8'($urandom); end
         step();
      end
      rand_mode = 0;
      n = 0;
      while ((model_busy || fifo.size() > 0) && n < 600) begin step(); n++; end
      repeat (3) step();
      check("t5_drained", (model_busy || fifo.size() > 0), 0);
      check("t5_rx_count", rx_log.size(), pushed.size());
      for (int i = 0; i < rx_log.size() && i < pushed.size(); i++) check("t5_rx_order", rx_log[i], pushed[i]);
      check("t5_wr_count", wr_log.size(), acc_log.size());
      for (int i = 0; i < wr_log.size() && i < acc_log.size(); i++) check("t5_wr_order", wr_log[i], acc_log[i]);

      // Reset while a write is stalled.
      wr_stall = 50;
      tx_req_now = 1; tx_byte_now = 8'hA5;
      n = 0;
      do begin step(); n++; end while (wrreq_o !== 1'b1 && n < 200);
      check("t6_write_seen", wrreq_o, 1);
      step();
      #1;
      do_reset();
      wr_stall = 0;
      kind_log.delete();
      repeat (30) step();
      check("t6_restart_seen", kind_log.size() > 0, 1);
      if (kind_log.size() > 0) check("t6_restart_kind", kind_log[0], K_DATA);

`ifdef JTAG_POLL_TIMEOUT_EN
      // Waitrequest stuck high.
      stall_plan.push_back(1000);
      to_count = 0; drops = 0;
      n = 0;
      while (drops == 0 && n < 100) begin step(); n++; end
      kind_log.delete();
      n = 0;
      while (kind_log.size() == 0 && n < 60) begin step(); n++; end
      repeat (3) step();
      check("t7_drops", drops, 1);
      check("t7_timeout_pulses", to_count, 1);
      check("t7_resumed", kind_log.size() > 0, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/jtag_uart_avalon_poller.md
Name: jtag_uart_avalon_poller

Overview:
- Avalon-MM master sitting directly upstream of the JTAG command decoder.
- Polls the JTAG-UART slave data register and emits each received host byte as a one-cycle-valid byte stream, which feeds the decoder's two-stage input pipeline.
- Also provides a single-byte transmit path so the outer state machine can send status/ack bytes back to the host. Before each write it checks WSPACE in the control register.

Parameters:
- POLL_GAP, 16, idle cycles between polls when the RX FIFO was empty (0 = back-to-back polling).
- TIMEOUT_CYC, 1024, waitrequest stall limit in cycles; used only with the optional feature.

Ports:
- iCLK  in  1  system clock
- iRST  in  1  asynchronous active-high reset
- oJTAG_SLAVE_ADDR  out  1  0 = data register, 1 = control register
- oJTAG_SLAVE_RDREQ  out  1  Avalon read
- iJTAG_SLAVE_RDDATA  in  32  read data; valid when RDREQ=1 and WAIT=0
- oJTAG_SLAVE_WRREQ  out  1  Avalon write
- oJTAG_SLAVE_WRDATA  out  32  {24'd0, byte}
- iJTAG_SLAVE_WAIT  in  1  Avalon waitrequest
- oDATA_TO_PARSE  out  8  received byte
- oDATA_TO_PARSE_VALID  out  1  one-cycle strobe per received byte
- iTX_BYTE  in  8  byte to send to host
- iTX_REQ  in  1  transmit request
- oTX_BUSY  out  1  high while a TX byte is pending or being written

Behaviour:
- Reset (async) puts every output to 0 and the FSM to S_GAP with the gap counter at 0. Any in-flight Avalon request drops immediately. A pending TX byte is discarded.
- Avalon rules:
  - A request asserts together with its ADDR/WRDATA and holds all of them stable while WAIT=1.
  - A transfer completes in the cycle where the request is 1 and WAIT is 0. The request deasserts in the next cycle.
  - Read latency is 0, so RDDATA is sampled in the completion cycle.
- FSM states:
  - S_GAP: count POLL_GAP cycles. At terminal count, go to S_RD_CTRL if a TX byte is pending, else S_RD_DATA.
  - S_RD_DATA: addr=0, RDREQ=1. On completion:
    - If RDDATA[15] (RVALID)=1: register RDDATA[7:0] into oDATA_TO_PARSE and pulse VALID in the following cycle.
    - If RVALID=1 and RDDATA[31:16] (RAVAIL) > 1 and no TX is pending, go to S_RD_DATA again with no gap.
    - Otherwise go to S_GAP.
  - S_RD_CTRL: addr=1, RDREQ=1. On completion, go to S_WR_DATA if RDDATA[31:16] (WSPACE) != 0, else S_RD_DATA. The TX byte stays pending and is retried after the next gap.
  - S_WR_DATA: addr=0, WRREQ=1, WRDATA={24'd0, tx_byte}. On completion clear tx_pending and go to S_RD_DATA, so RX is never starved by TX.
- TX handshake:
  - iTX_REQ is sampled only when oTX_BUSY=0. The byte is latched and oTX_BUSY rises on the next cycle.
  - oTX_BUSY stays high through the write-completion cycle and falls the cycle after.
  - iTX_REQ while busy is ignored (not queued).
- RX latency: VALID asserts exactly 1 cycle after the read-completion cycle. At most one VALID per read. The minimum spacing between VALIDs is the read duration + 1, so no back-pressure is needed.
- Reads with RVALID=0 produce no strobe. The byte value is then don't-care but holds its last value.
- Simultaneous iTX_REQ with a read completion: both are honoured. The latch and the strobe are independent.

Optional Feature:
- Macro: JTAG_POLL_TIMEOUT_EN.
- With the macro:
  - A stall counter increments each cycle a request is held with WAIT=1.
  - When it reaches TIMEOUT_CYC, the request is dropped and the FSM returns to S_GAP. Any pending TX byte is kept.
  - Extra port oTIMEOUT (out, 1) pulses for one cycle.
  - The counter clears on every completion and on reset.
- Without the macro: no counter, no oTIMEOUT port, and requests hold indefinitely.

Decomposition:
- Shared package/header (alongside the decoder params):
  - register addresses JTAG_ADDR_DATA=0, JTAG_ADDR_CTRL=1
  - field positions RVALID_BIT=15, RAVAIL_MSB/LSB=31/16, WSPACE_MSB/LSB=31/16
  - the FSM state encodings
- Single module, no sub-module. The gap and timeout counters are inline.

Test Plan:
- FIFO preload 0xFE,0x01 with WAIT=0: two back-to-back reads (RAVAIL=2, then 1). VALID pulses with 0xFE then 0x01, each 1 cycle after its completion. Next read only after a 16-cycle gap.
- WAIT held high for 5 cycles on a data read: RDREQ and ADDR stay stable for 6 cycles, exactly one VALID, the byte is taken from the final cycle's RDDATA.
- iTX_REQ with byte 0x5A and WSPACE=64: sequence is control read, write with WRDATA=0x0000005A, then data read. oTX_BUSY falls the cycle after write completion.
- TX with WSPACE=0 three times, then 8: no write until the 4th control read. oTX_BUSY stays high throughout. A second iTX_REQ with 0x11 mid-way is ignored.
- iRST asserted mid-write while WAIT=1: WRREQ=0, VALID=0 and TX_BUSY=0 asynchronously. After release, polling restarts after POLL_GAP.
- With JTAG_POLL_TIMEOUT_EN and TIMEOUT_CYC=8, WAIT stuck at 1: RDREQ drops after 8 stalled cycles, oTIMEOUT pulses once, and polling resumes.
